// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encodings and
// the counter-width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 1;
    end
    if (res < 1) begin
      res = 1;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/FA2.sv
// Single 1-bit full-adder cell used by the bit-serial adder sequencer.
module FA2 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one FA2 cell, one bit per clock, LSB first.
// Define SERIAL_ADD_SUB_EN to enable two's-complement subtract via the sub port.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             c_msb_in_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] s_sh_r;
  logic [WIDTH-1:0] s_next_s;
  logic             b_bit_s;
  logic             carry_init_s;
  logic             sum_bit_s;
  logic             co_s;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_r;

  // Latch the subtract request alongside the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      sub_r <= sub;
    end else begin
      sub_r <= sub_r;
    end
  end

  assign b_bit_s      = b_sh_r[0] ^ sub_r;
  assign carry_init_s = sub;
`else
  logic unused_sub_s;

  assign unused_sub_s = sub;
  assign b_bit_s      = b_sh_r[0];
  assign carry_init_s = 1'b0;
`endif

  FA2 u_fa (
    .a  (a_sh_r[0]),
    .b  (b_bit_s),
    .ci (carry_r),
    .s  (sum_bit_s),
    .co (co_s)
  );

  // The newest sum bit enters from the MSB side; after WIDTH bits it is the result.
  assign s_next_s = {sum_bit_s, s_sh_r};

  // Sequencer FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      carry_r    <= 1'b0;
      c_msb_in_r <= 1'b0;
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      s_sh_r     <= {(WIDTH-1){1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      sum        <= {WIDTH{1'b0}};
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r  <= op_a;
            b_sh_r  <= op_b;
            carry_r <= carry_init_s;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          s_sh_r  <= s_next_s[WIDTH-1:1];
          carry_r <= co_s;
          cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(WIDTH - 2)) begin
            c_msb_in_r <= co_s;
          end else begin
            c_msb_in_r <= c_msb_in_r;
          end
          if (cnt_r == CW'(WIDTH - 1)) begin
            sum     <= s_next_s;
            cout    <= co_s;
            ovf     <= c_msb_in_r ^ co_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): stimulus pushes expected
// {ovf,cout,sum}; a negedge monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int         n_cmp;
  int         n_err;
  logic [9:0] sb_q[$];
  logic [7:0] last_sum;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        check("result", {22'd0, ovf, cout, sum}, {22'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    lat   = 0;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    sb_q.push_back({eo, ec, es});
    #1;
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    sub   = ~s;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    while (!done && lat < 20) begin
      if (lat == 4) begin
        check("busy_mid_run", {31'd0, busy}, 32'd1);
        check("sum_held_in_run", {24'd0, sum}, {24'd0, last_sum});
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 32'd8);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    last_sum = es;
    @(posedge clk);
    #1;
    check("done_single_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    int dpos[$];
    n_cmp    = 0;
    n_err    = 0;
    last_sum = 8'h00;
    rst      = 1'b1;
    start    = 1'b0;
    op_a     = 8'h00;
    op_b     = 8'h00;
    sub      = 1'b0;
    #12;
    check("reset_outputs", {20'd0, busy, done, cout, ovf, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1);
`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
    run_op(8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
`endif

    // Start pulsed mid-run with other operands must be ignored.
    op_a  = 8'h12;
    op_b  = 8'h34;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    sb_q.push_back({1'b0, 1'b0, 8'h46});
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      if (lat == 3) begin
        op_a  = 8'hAA;
        op_b  = 8'h11;
        start = 1'b1;
      end else if (lat == 5) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_ignored_start", lat, 32'd8);
    last_sum = 8'h46;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("no_second_done", ndone, 32'd0);

    // Reset in the middle of a run aborts it asynchronously.
    op_a  = 8'h55;
    op_b  = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {20'd0, busy, done, cout, ovf, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_sum = 8'h00;
    @(posedge clk);
    #1;
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Start held high: accepted every 10 cycles, single-cycle done pulses.
    op_a  = 8'h20;
    op_b  = 8'h03;
    sub   = 1'b0;
    start = 1'b1;
    repeat (3) sb_q.push_back({1'b0, 1'b0, 8'h23});
    @(posedge clk);
    #1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done) dpos.push_back(c);
      if (c == 4) check("sum_stable_before", {24'd0, sum}, 32'h03);
      if (c == 12) check("sum_stable_between", {24'd0, sum}, 32'h23);
      if (c == 20) start = 1'b0;
    end
    check("cont_done_count", dpos.size(), 32'd3);
    if (dpos.size() == 3) begin
      check("cont_done0", dpos[0], 32'd8);
      check("cont_done1", dpos[1], 32'd18);
      check("cont_done2", dpos[2], 32'd28);
    end
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
